// File: rtl/m3_seq_pkg.sv
// Shared types and default constants for the motor soft-start / soft-reversal sequencer.
package m3_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    REVDN = 3'd3,
    COAST = 3'd4
  } seqState_t;

  localparam int unsigned DEF_FREQ_W    = 10;
  localparam int unsigned DEF_RAMP_DIV  = 1000;
  localparam int unsigned DEF_COAST_CYC = 50000;

  // Bridge is energised in every state that moves or holds frequency.
  function automatic logic isDriving(input seqState_t s);
    return (s == RAMP) || (s == RUN) || (s == REVDN);
  endfunction

endpackage

// File: rtl/m3_ramp_tick.sv
// Ramp rate divider: pulses tick once every DIV enabled cycles, restartable via clr.
module m3_ramp_tick #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // tick must not depend on clr: clr is derived from the sequencer's next state.
  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m3_ramp_sequencer.sv
// Rate-limited frequency ramp with ramp-down / coast / ramp-up direction reversal and eStop override.
module m3_ramp_sequencer
  import m3_seq_pkg::*;
#(
  parameter int unsigned FREQ_W    = DEF_FREQ_W,
  parameter int unsigned RAMP_DIV  = DEF_RAMP_DIV,
  parameter int unsigned COAST_CYC = DEF_COAST_CYC
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [FREQ_W-1:0] cmdFreq,
  input  logic              cmdDir,
  input  logic              eStop,
  output logic              m3start,
  output logic              m3invOrStop,
  output logic [FREQ_W-1:0] m3freq,
  output logic              busy,
  output logic              atSpeed,
  output logic [2:0]        seqState
);

  localparam int unsigned CCW = $clog2(COAST_CYC + 1);

  seqState_t         state, stNext;
  logic [FREQ_W-1:0] curFreq, curNext;
  logic [FREQ_W-1:0] tgtFreq, tgtNext;
  logic [FREQ_W-1:0] pendFreq, pendFreqNext;
  logic [FREQ_W-1:0] stepped;
  logic              dir, dirNext;
  logic              pendDir, pendDirNext;
  logic [CCW-1:0]    coastCnt, coastNext;
  logic              cmdAcc;
  logic              divEn, divClr, tick;

  assign cmdAcc = cmdValid & cmdReady;
  assign divEn  = (state == RAMP) || (state == REVDN);
  // A retarget restarts the step period so every step after a command is a full period.
  assign divClr = (stNext != state) || cmdAcc || !divEn;

  m3_ramp_tick #(
    .DIV (RAMP_DIV)
  ) uTick (
    .clk  (clk),
    .nRst (nRst),
    .clr  (divClr),
    .en   (divEn),
    .tick (tick)
  );

  always_comb begin
    stepped = curFreq;
    if ((curFreq < tgtFreq) && (curFreq != '1)) begin
      stepped = curFreq + 1'b1;
    end else if ((curFreq > tgtFreq) && (curFreq != '0)) begin
      stepped = curFreq - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      curFreq  <= '0;
      tgtFreq  <= '0;
      dir      <= 1'b0;
      pendFreq <= '0;
      pendDir  <= 1'b0;
      coastCnt <= '0;
    end else begin
      state    <= stNext;
      curFreq  <= curNext;
      tgtFreq  <= tgtNext;
      dir      <= dirNext;
      pendFreq <= pendFreqNext;
      pendDir  <= pendDirNext;
      coastCnt <= coastNext;
    end
  end

  always_comb begin
    stNext       = state;
    curNext      = curFreq;
    tgtNext      = tgtFreq;
    dirNext      = dir;
    pendFreqNext = pendFreq;
    pendDirNext  = pendDir;
    coastNext    = '0;
    if (eStop) begin
      stNext  = IDLE;
      curNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          curNext = '0;
          if (cmdAcc && (cmdFreq != '0)) begin
            tgtNext = cmdFreq;
            dirNext = cmdDir;
            stNext  = RAMP;
          end
        end
        RAMP, RUN: begin
          if (cmdAcc) begin
            // At zero speed a direction mismatch needs no reversal; dir stays put while energised.
            if ((cmdDir == dir) || (curFreq == '0)) begin
              tgtNext = cmdFreq;
              if (cmdFreq == curFreq) begin
                stNext = (cmdFreq != '0) ? RUN : IDLE;
              end else begin
                stNext = RAMP;
              end
            end else begin
              pendFreqNext = cmdFreq;
              pendDirNext  = cmdDir;
              tgtNext      = '0;
              stNext       = REVDN;
            end
          end else if (state == RAMP) begin
            if (curFreq == tgtFreq) begin
              stNext = (tgtFreq != '0) ? RUN : IDLE;
            end else if (tick) begin
              curNext = stepped;
              if (stepped == tgtFreq) begin
                stNext = (tgtFreq != '0) ? RUN : IDLE;
              end
            end
          end
        end
        REVDN: begin
          if (curFreq == '0) begin
            stNext = COAST;
          end else if (tick) begin
            curNext = stepped;
            if (stepped == '0) begin
              stNext = COAST;
            end
          end
        end
        COAST: begin
          if (coastCnt == CCW'(COAST_CYC - 1)) begin
            dirNext = pendDir;
            tgtNext = pendFreq;
            stNext  = (pendFreq != '0) ? RAMP : IDLE;
          end else begin
            coastNext = coastCnt + 1'b1;
          end
        end
        default: stNext = IDLE;
      endcase
    end
  end

  always_comb begin
    m3start     = isDriving(state);
    m3invOrStop = dir;
    m3freq      = curFreq;
    busy        = (state == RAMP) || (state == REVDN) || (state == COAST);
    atSpeed     = (state == RUN);
    seqState    = state;
    cmdReady    = !eStop && ((state == IDLE) || (state == RAMP) || (state == RUN));
  end

endmodule

// File: tb/tb_m3_ramp_sequencer.sv
// Bench for m3_ramp_sequencer: directed scenarios with literal expectations plus randomized commands vs a timer-based model.
module tb_m3_ramp_sequencer;

  localparam int unsigned FW = 10;
  localparam int unsigned RD = 4;
  localparam int unsigned CC = 8;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          cmdValid = 1'b0;
  logic [FW-1:0] cmdFreq = '0;
  logic          cmdDir = 1'b0;
  logic          eStop = 1'b0;
  logic          cmdReady, m3start, m3invOrStop, busy, atSpeed;
  logic [FW-1:0] m3freq;
  logic [2:0]    seqState;

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn   = 1'b0;

  // Model state: 0 idle, 1 ramping, 2 running, 3 reversing down, 4 coasting.
  int mState, mFreq, mTgt, mDir, mPendF, mPendD, mTimer, mCoastLeft;

  m3_ramp_sequencer #(
    .FREQ_W    (FW),
    .RAMP_DIV  (RD),
    .COAST_CYC (CC)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdFreq     (cmdFreq),
    .cmdDir      (cmdDir),
    .eStop       (eStop),
    .m3start     (m3start),
    .m3invOrStop (m3invOrStop),
    .m3freq      (m3freq),
    .busy        (busy),
    .atSpeed     (atSpeed),
    .seqState    (seqState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit acc;
    acc = cmdValid && !eStop && (mState <= 2);
    if (eStop) begin
      mState = 0;
      mFreq  = 0;
    end else begin
      case (mState)
        0: if (acc && cmdFreq != '0) begin
          mTgt = int'(cmdFreq); mDir = int'(cmdDir); mState = 1; mTimer = RD;
        end
        1, 2: begin
          if (acc) begin
            if (int'(cmdDir) == mDir || mFreq == 0) begin
              mTgt = int'(cmdFreq);
              if (mTgt == mFreq) mState = (mTgt != 0) ? 2 : 0;
              else begin mState = 1; mTimer = RD; end
            end else begin
              mPendF = int'(cmdFreq); mPendD = int'(cmdDir); mTgt = 0; mState = 3; mTimer = RD;
            end
          end else if (mState == 1) begin
            if (mFreq == mTgt) mState = (mTgt != 0) ? 2 : 0;
            else begin
              mTimer--;
              if (mTimer == 0) begin
                mFreq  = (mTgt > mFreq) ? mFreq + 1 : mFreq - 1;
                mTimer = RD;
                if (mFreq == mTgt) mState = (mTgt != 0) ? 2 : 0;
              end
            end
          end
        end
        3: begin
          mTimer--;
          if (mTimer == 0) begin
            mFreq--; mTimer = RD;
            if (mFreq == 0) begin mState = 4; mCoastLeft = CC; end
          end
        end
        4: begin
          mCoastLeft--;
          if (mCoastLeft == 0) begin
            mDir = mPendD; mTgt = mPendF; mState = (mPendF != 0) ? 1 : 0; mTimer = RD;
          end
        end
        default: mState = 0;
      endcase
    end
  endtask

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mState = 0; mFreq = 0; mTgt = 0; mDir = 0;
      mPendF = 0; mPendD = 0; mTimer = 0; mCoastLeft = 0;
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("m3start",     32'(m3start),     (mState >= 1 && mState <= 3) ? 1 : 0);
      chk("m3invOrStop", 32'(m3invOrStop), 32'(mDir));
      chk("m3freq",      32'(m3freq),      32'(mFreq));
      chk("busy",        32'(busy),        (mState == 1 || mState == 3 || mState == 4) ? 1 : 0);
      chk("atSpeed",     32'(atSpeed),     (mState == 2) ? 1 : 0);
      chk("seqState",    32'(seqState),    32'(mState));
      chk("cmdReady",    32'(cmdReady),    (!eStop && mState <= 2) ? 1 : 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sendCmd(input int f, input bit d);
    cmdValid = 1'b1;
    cmdFreq  = FW'(f);
    cmdDir   = d;
    cycles(1);
    cmdValid = 1'b0;
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, "_m3start"},  32'(m3start), 0);
    chk({tag, "_m3freq"},   32'(m3freq), 0);
    chk({tag, "_inv"},      32'(m3invOrStop), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_atSpeed"},  32'(atSpeed), 0);
    chk({tag, "_seqState"}, 32'(seqState), 0);
    chk({tag, "_cmdReady"}, 32'(cmdReady), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chkResetOuts("reset");
    nRst  = 1'b1;
    chkEn = 1'b1;
    cycles(2);

    // Ramp 0 -> 10: steps every 4 cycles, RUN on the edge writing 10.
    sendCmd(10, 1'b0);
    chk("s1_start", 32'(m3start), 1);
    chk("s1_state", 32'(seqState), 1);
    cycles(39);
    chk("s1_freq39", 32'(m3freq), 9);
    chk("s1_atSpeed39", 32'(atSpeed), 0);
    cycles(1);
    chk("s1_freq40", 32'(m3freq), 10);
    chk("s1_atSpeed40", 32'(atSpeed), 1);

    // Same-direction slowdown 10 -> 4.
    sendCmd(4, 1'b0);
    chk("s2_state", 32'(seqState), 1);
    chk("s2_start", 32'(m3start), 1);
    cycles(23);
    chk("s2_freq23", 32'(m3freq), 5);
    cycles(1);
    chk("s2_freq24", 32'(m3freq), 4);
    chk("s2_atSpeed", 32'(atSpeed), 1);
    chk("s2_dir", 32'(m3invOrStop), 0);
    sendCmd(10, 1'b0);
    cycles(30);
    chk("s2_back10", 32'(m3freq), 10);

    // Reversal 10 fwd -> 6 rev.
    sendCmd(6, 1'b1);
    chk("s3_revdn", 32'(seqState), 3);
    chk("s3_rdy", 32'(cmdReady), 0);
    cycles(39);
    chk("s3_freq39", 32'(m3freq), 1);
    chk("s3_state39", 32'(seqState), 3);
    cycles(1);
    chk("s3_coast", 32'(seqState), 4);
    chk("s3_coastStart", 32'(m3start), 0);
    chk("s3_coastFreq", 32'(m3freq), 0);
    chk("s3_coastRdy", 32'(cmdReady), 0);
    chk("s3_coastDir", 32'(m3invOrStop), 0);
    cycles(7);
    chk("s3_coastEnd", 32'(seqState), 4);
    chk("s3_coastEndDir", 32'(m3invOrStop), 0);
    cycles(1);
    chk("s3_rampState", 32'(seqState), 1);
    chk("s3_rampStart", 32'(m3start), 1);
    chk("s3_rampDir", 32'(m3invOrStop), 1);
    cycles(23);
    chk("s3_freq23", 32'(m3freq), 5);
    cycles(1);
    chk("s3_freq24", 32'(m3freq), 6);
    chk("s3_atSpeed", 32'(atSpeed), 1);

    // eStop mid-ramp with a simultaneous command.
    eStop = 1'b1;
    cycles(1);
    eStop = 1'b0;
    chk("s4_idleDirKept", 32'(m3invOrStop), 1);
    sendCmd(10, 1'b1);
    cycles(21);
    chk("s4_freq5", 32'(m3freq), 5);
    eStop = 1'b1; cmdValid = 1'b1; cmdFreq = FW'(3); cmdDir = 1'b0;
    cycles(1);
    chk("s4_state", 32'(seqState), 0);
    chk("s4_freq", 32'(m3freq), 0);
    chk("s4_start", 32'(m3start), 0);
    chk("s4_dir", 32'(m3invOrStop), 1);
    chk("s4_rdy", 32'(cmdReady), 0);
    eStop = 1'b0; cmdValid = 1'b0;
    cycles(1);
    chk("s4_notAccepted", 32'(seqState), 0);
    sendCmd(3, 1'b1);
    chk("s4_fresh", 32'(m3freq), 0);
    cycles(3);
    chk("s4_fresh3", 32'(m3freq), 0);
    cycles(1);
    chk("s4_fresh4", 32'(m3freq), 1);
    cycles(10);
    chk("s4_run3", 32'(atSpeed), 1);

    // Controlled stop mid-ramp, then a zero command in IDLE.
    eStop = 1'b1;
    cycles(1);
    eStop = 1'b0;
    sendCmd(10, 1'b0);
    cycles(13);
    chk("s5_freq3", 32'(m3freq), 3);
    sendCmd(0, 1'b0);
    chk("s5_state", 32'(seqState), 1);
    cycles(11);
    chk("s5_freq1", 32'(m3freq), 1);
    cycles(1);
    chk("s5_freq0", 32'(m3freq), 0);
    chk("s5_idle", 32'(seqState), 0);
    chk("s5_start", 32'(m3start), 0);
    chk("s5_rdy", 32'(cmdReady), 1);
    sendCmd(0, 1'b0);
    chk("s5_zeroIdle", 32'(seqState), 0);
    chk("s5_zeroStart", 32'(m3start), 0);

    // Asynchronous reset in COAST discards the pending command.
    sendCmd(2, 1'b0);
    cycles(10);
    chk("s6_run2", 32'(atSpeed), 1);
    sendCmd(5, 1'b1);
    cycles(10);
    chk("s6_coast", 32'(seqState), 4);
    #1 nRst = 1'b0;
    #1 chkResetOuts("s6_async");
    cycles(2);
    nRst = 1'b1;
    cycles(20);
    chk("s6_stayIdle", 32'(seqState), 0);
    chk("s6_dir", 32'(m3invOrStop), 0);

    // Randomized commands and eStop pulses.
    repeat (3000) begin
      eStop    = ($urandom_range(0, 63) == 0);
      cmdValid = ($urandom_range(0, 11) == 0);
      cmdFreq  = ($urandom_range(0, 7) == 0) ? '0 : FW'($urandom_range(1, 12));
      cmdDir   = 1'($urandom_range(0, 1));
      cycles(1);
    end
    cmdValid = 1'b0;
    eStop    = 1'b0;
    cycles(2);
    chkEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/m3_ramp_sequencer.md
# m3_ramp_sequencer

Soft-start / soft-reversal sequencer for the three-phase motor driver. Sits in the 10 MHz motor clock domain between the command source (UART config path or panel logic) and the driver's `m3start` / `m3invOrStop` / `m3freq` inputs. Replaces the raw level drive of those inputs with a rate-limited frequency ramp. Direction reversal is done as ramp-to-zero, then coast, then ramp-up. An emergency stop overrides everything.

## Interface
Parameters:
- `FREQ_W`, 10, width of frequency word
- `RAMP_DIV`, 1000, clk cycles per ±1 frequency step (100 µs at 10 MHz); legal ≥ 2
- `COAST_CYC`, 50000, clk cycles bridge held off between ramp-down and reversed ramp-up; legal ≥ 1

Ports:
- `clk`  in  1  motor clock (10 MHz); single clock domain
- `nRst`  in  1  asynchronous active-low reset
- `cmdValid`  in  1  command present
- `cmdReady`  out  1  command accepted when `cmdValid & cmdReady` at rising edge
- `cmdFreq`  in  FREQ_W  target frequency; 0 = controlled stop
- `cmdDir`  in  1  target direction, 1 = reverse
- `eStop`  in  1  emergency stop, level, sampled each cycle
- `m3start`  out  1  bridge enable to driver
- `m3invOrStop`  out  1  direction to driver
- `m3freq`  out  FREQ_W  current frequency to driver
- `busy`  out  1  state is RAMP, REVDN or COAST
- `atSpeed`  out  1  state is RUN
- `seqState`  out  3  current state encoding (debug / UART show)

## Operation
- States: IDLE=0, RAMP=1, RUN=2, REVDN=3, COAST=4. Outputs are registered.
- Internal registers: `curFreq` (drives `m3freq`), `tgtFreq`, `dir` (drives `m3invOrStop`), `pendFreq`, `pendDir`, divider, coast counter.
- `cmdReady` = !eStop & state ∈ {IDLE, RAMP, RUN}. It is 0 in REVDN and COAST.
- IDLE: `m3start`=0, `curFreq`=0.
  - Accepted cmd with `cmdFreq`>0: `tgtFreq`←cmdFreq, `dir`←cmdDir, go RAMP.
  - Accepted cmd with `cmdFreq`=0: accepted, no state change.
- RAMP: `m3start`=1. On each divider tick, `curFreq` moves 1 toward `tgtFreq`.
  - When `curFreq` equals `tgtFreq` after a step (or already equals it): go RUN if `tgtFreq`>0, else IDLE with `m3start`←0.
- RUN: `m3start`=1, frequency constant.
- Accepted cmd in RAMP or RUN:
  - Same direction, or `curFreq`=0: `tgtFreq`←cmdFreq, go or stay RAMP. Go RUN if the new target equals `curFreq`.
  - Opposite direction with `curFreq`>0: `pendFreq`←cmdFreq, `pendDir`←cmdDir, `tgtFreq`←0, go REVDN.
- REVDN: ramps like RAMP toward 0 with `m3start`=1. At `curFreq`=0, go COAST.
- COAST: `m3start`=0 for exactly COAST_CYC cycles. Then `dir`←pendDir, `tgtFreq`←pendFreq, and go RAMP (or IDLE if `pendFreq`=0).
- eStop high: next edge forces IDLE, `curFreq`=0, `m3start`=0, and clears the divider and coast counter. `dir` is kept. eStop has priority over a simultaneous cmd, which is not accepted.
- Divider: cleared on every state change and outside RAMP/REVDN. A tick occurs in the cycle the count reaches RAMP_DIV-1; the count then wraps to 0.
- Frequency arithmetic is saturating within 0..2^FREQ_W-1 and never overshoots the target.

## Timing
- Reset values: state IDLE, `m3start`=0, `m3invOrStop`=0, `m3freq`=0, `busy`=0, `atSpeed`=0, `cmdReady`=1 (while eStop is low).
- Cmd accepted at edge N: `m3start`=1 and state RAMP from N+1. First `m3freq` increment is visible at N+RAMP_DIV. Each later step follows RAMP_DIV cycles after the previous one.
- Ramp 0→F takes F·RAMP_DIV cycles from entry to RAMP.
- The edge that writes `curFreq`=tgt also switches state to RUN.
- Reversal from F: F·RAMP_DIV cycles in REVDN, then COAST_CYC cycles with `m3start`=0. `m3invOrStop` flips in the same edge that enters RAMP.
- `m3invOrStop` never changes while `m3start`=1.
- eStop to outputs off: 1 cycle.

## Structure
- Package `m3_seq_pkg`: state enum/localparams (IDLE..COAST), default FREQ_W, RAMP_DIV, COAST_CYC constants.
- Sub-module `m3_ramp_tick`: parameterised divider with `clr` and `en` inputs and a `tick` output.
- State machine, frequency stepper and coast counter live in `m3_ramp_sequencer`.

## Test plan
Bench parameters: RAMP_DIV=4, COAST_CYC=8.
- Reset, then cmd (10, dir 0) → `m3start`=1 next cycle; `m3freq` reaches 10 after 40 cycles; `atSpeed`=1 in the same cycle.
- RUN at 10, cmd (4, dir 0) → ramps down to 4 in 24 cycles; `m3start` stays 1; `dir` unchanged.
- RUN at 10 dir 0, cmd (6, dir 1) → REVDN for 40 cycles, COAST with `m3start`=0 for 8 cycles, `m3invOrStop`=1 on RAMP entry, `m3freq`=6 after 24 more cycles; `cmdReady`=0 during REVDN/COAST.
- Mid-ramp at 5, eStop pulse together with `cmdValid` → next cycle IDLE, `m3freq`=0, `m3start`=0, cmd not accepted; after release, a fresh cmd starts from 0.
- RAMP toward 10, cmd (0, dir 0) at `m3freq`=3 → ramps to 0 in 12 cycles, ends in IDLE with `m3start`=0; cmd (0) in IDLE → accepted, no change.
- Reset asserted mid-COAST → all outputs take reset values asynchronously; the pending command is discarded.
